hex_display_arbiter: RTL and testbench



---
 rtl/seg_pkg.sv | 6 +
 rtl/hex_7seg.sv | 29 ++
 rtl/hex_display_arbiter.sv | 108 ++++++++++
 tb/tb_hex_display_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared display types: arbiter state encoding, blank segment pattern and digit width.
package seg_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam int DIGIT_W = 4;
endpackage

// File: rtl/hex_7seg.sv
// Hex nibble to active-low 7-segment pattern, segment a = bit 0 .. segment g = bit 6.
module hex_7seg
   import seg_pkg::*;
(
   input  logic [DIGIT_W-1:0] hex,
   output logic [6:0]         seg
);
   always_comb begin
      seg = SEG_BLANK;
      case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
   end
endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin sharing of a 4-digit hex display between NREQ requesters; the granted value
// is latched and held for at least DWELL cycles before the display can change hands.
module hex_display_arbiter
   import seg_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int DWELL = 50_000_000,
   parameter int CW    = 26
)(
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [16*NREQ-1:0] data,
   output logic [NREQ-1:0]   grant,
   output logic [2:0]        owner,
   output logic              busy,
   output logic              shown,
   output logic [6:0]        HEX0,
   output logic [6:0]        HEX1,
   output logic [6:0]        HEX2,
   output logic [6:0]        HEX3
);
   // First requester at or above p, wrapping at NREQ: rotate so p lands on bit 0.
   function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] p);
      logic [2*NREQ-1:0] dbl;
      logic [NREQ-1:0]   rot;
      int                off;
      int                sum;
      dbl = {r, r} >> p;
      rot = dbl[NREQ-1:0];
      off = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) off = k;
      end
      sum = int'(p) + off;
      if (sum >= NREQ) sum = sum - NREQ;
      return 3'(sum);
   endfunction

   function automatic logic [2:0] rr_next(input logic [2:0] i);
      return (int'(i) == NREQ - 1) ? 3'd0 : i + 3'd1;
   endfunction

   state_t          state;
   logic [2:0]      sel;
   logic [2:0]      ptr;
   logic [2:0]      pick;
   logic [CW-1:0]   count;
   logic [15:0]     value;
   logic [6:0]      seg [4];

   assign pick = rr_pick(req, ptr);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         sel   <= '0;
         ptr   <= '0;
         count <= '0;
         value <= '0;
         grant <= '0;
         owner <= '0;
         busy  <= 1'b0;
         shown <= 1'b0;
      end else begin
         grant <= '0;
         case (state)
            IDLE: begin
               if (|req) begin
                  sel   <= pick;
                  grant <= NREQ'(1) << pick;
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end
            LOAD: begin
               value <= 16'(data >> {sel, 4'b0000});
               owner <= sel;
               shown <= 1'b1;
               count <= '0;
               ptr   <= rr_next(sel);
               state <= HOLD;
            end
            HOLD: begin
               count <= count + 1'b1;
               // LOAD plus DWELL-1 HOLD cycles gives exactly DWELL busy cycles.
               if (count == CW'(DWELL - 2)) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar d = 0; d < 4; d++) begin : g_digit
      hex_7seg u_dec (
         .hex (value[DIGIT_W*d +: DIGIT_W]),
         .seg (seg[d])
      );
   end

   assign HEX0 = shown ? seg[0] : SEG_BLANK;
   assign HEX1 = shown ? seg[1] : SEG_BLANK;
   assign HEX2 = shown ? seg[2] : SEG_BLANK;
   assign HEX3 = shown ? seg[3] : SEG_BLANK;
endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter with NREQ=3, DWELL=8: directed scenarios then random traffic.
module tb_hex_display_arbiter;
   localparam int NREQ  = 3;
   localparam int DWELL = 8;
   localparam int CW    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [47:0] data;
   logic [2:0]  grant;
   logic [2:0]  owner;
   logic        busy;
   logic        shown;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3;

   always #5 clk = ~clk;

   hex_display_arbiter #(.NREQ(NREQ), .DWELL(DWELL), .CW(CW)) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .req      (req),
      .data     (data),
      .grant    (grant),
      .owner    (owner),
      .busy     (busy),
      .shown    (shown),
      .HEX0     (HEX0),
      .HEX1     (HEX1),
      .HEX2     (HEX2),
      .HEX3     (HEX3)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference: 'left' counts remaining busy cycles; a grant may only happen when it is 0.
   logic [15:0] e_value;
   logic [2:0]  e_grant;
   int          e_owner;
   bit          e_shown;
   int          left;
   bit          cap_pending;
   int          cap_idx;
   int          ptr;

   task automatic model_reset();
      e_value = '0; e_grant = '0; e_owner = 0; e_shown = 0;
      left = 0; cap_pending = 0; cap_idx = 0; ptr = 0;
   endtask

   task automatic model_step();
      int w;
      w = -1;
      e_grant = '0;
      if (cap_pending) begin
         e_value     = data[16*cap_idx +: 16];
         e_owner     = cap_idx;
         e_shown     = 1;
         ptr         = (cap_idx + 1) % NREQ;
         cap_pending = 0;
      end
      if (left == 0) begin
         for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && req[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
         end
         if (w >= 0) begin
            e_grant     = 3'b001 << w;
            cap_pending = 1;
            cap_idx     = w;
            left        = DWELL;
         end
      end else begin
         left--;
      end
   endtask

   function automatic logic [6:0] exp_hex(int d);
      return e_shown ? seg_tab[e_value[4*d +: 4]] : 7'h7F;
   endfunction

   task automatic check_eq(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_all();
      check_eq("grant", grant, e_grant);
      check_eq("busy", busy, left > 0);
      check_eq("shown", shown, e_shown);
      if (e_shown) check_eq("owner", owner, e_owner);
      check_eq("hex0", HEX0, exp_hex(0));
      check_eq("hex1", HEX1, exp_hex(1));
      check_eq("hex2", HEX2, exp_hex(2));
      check_eq("hex3", HEX3, exp_hex(3));
   endtask

   // One clock: model advances with the DUT edge, comparison on the falling edge.
   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      cyc++;
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      model_reset();
      tick();
      rst = 1'b0;
   endtask

   function automatic int first_bit(logic [2:0] v);
      for (int i = 0; i < 3; i++) if (v[i]) return i;
      return -1;
   endfunction

   int gcyc [4];
   int gidx [4];
   int ng;
   int bc;
   int wt [3];

   initial begin
      rst  = 1'b1;
      req  = '0;
      data = '0;
      model_reset();
      @(negedge clk);
      check_all();
      check_eq("rst_hex0", HEX0, 7'h7F);
      check_eq("rst_shown", shown, 0);
      tick();
      rst = 1'b0;

      // idle with no requests stays blank
      repeat (6) tick();
      check_eq("idle_hex3", HEX3, 7'h7F);
      check_eq("idle_busy", busy, 0);

      // single request, value 1234
      data[15:0] = 16'h1234;
      req = 3'b001;
      tick();
      check_eq("t2_grant", grant, 3'b001);
      req = '0;
      bc = busy ? 1 : 0;
      tick();
      check_eq("t2_hex3", HEX3, 7'h79);
      check_eq("t2_hex2", HEX2, 7'h24);
      check_eq("t2_hex1", HEX1, 7'h30);
      check_eq("t2_hex0", HEX0, 7'h19);
      check_eq("t2_owner", owner, 0);
      if (busy) bc++;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (busy) bc++;
      end
      check_eq("t2_busy_len", bc, 8);

      // simultaneous requests from a fresh pointer
      do_reset();
      data = {16'h0F0F, 16'h5678, 16'hABCD};
      req  = 3'b111;
      ng   = 0;
      for (int i = 0; i < 40 && ng < 3; i++) begin
         tick();
         if (grant != 0) begin
            gcyc[ng] = cyc;
            gidx[ng] = first_bit(grant);
            req = req & ~grant;
            ng++;
         end
      end
      check_eq("t3_ngrants", ng, 3);
      for (int i = 0; i < ng; i++) check_eq("t3_order", gidx[i], i);
      if (ng == 3) begin
         check_eq("t3_gap01", gcyc[1] - gcyc[0], 9);
         check_eq("t3_gap12", gcyc[2] - gcyc[1], 9);
      end
      repeat (10) tick();

      // request 1 arriving during request 0's hold waits for busy to fall
      data[15:0] = 16'h4242;
      data[31:16] = 16'h9E1D;
      req = 3'b001;
      ng  = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (grant != 0 && ng < 4) begin
            gcyc[ng] = cyc;
            gidx[ng] = first_bit(grant);
            req = req & ~grant;
            ng++;
         end
         if (i == 3) req[1] = 1'b1;
      end
      check_eq("t4_ngrants", ng, 2);
      if (ng == 2) begin
         check_eq("t4_first", gidx[0], 0);
         check_eq("t4_second", gidx[1], 1);
         check_eq("t4_gap", gcyc[1] - gcyc[0], 9);
      end

      // reset mid-hold blanks at once; afterwards lone req[2] wins
      do_reset();
      data[15:0] = 16'h5555;
      req = 3'b001;
      tick();
      req = '0;
      repeat (5) tick();
      rst = 1'b1;
      model_reset();
      #1;
      check_eq("t5_blank", HEX0, 7'h7F);
      check_eq("t5_busy", busy, 0);
      check_eq("t5_shown", shown, 0);
      tick();
      rst = 1'b0;
      data[47:32] = 16'hBEEF;
      req = 3'b100;
      tick();
      check_eq("t5_grant", grant, 3'b100);
      req = '0;

      // one-cycle pulse during hold is forgotten
      tick();
      tick();
      data[15:0] = 16'h7777;
      req = 3'b001;
      tick();
      req = '0;
      ng = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (grant != 0) ng++;
      end
      check_eq("t6_no_grant", ng, 0);
      check_eq("t6_hex3", HEX3, 7'h03);
      check_eq("t6_hex0", HEX0, 7'h0E);

      // random traffic
      do_reset();
      for (int i = 0; i < 3; i++) wt[i] = 0;
      for (int n = 0; n < 3000; n++) begin
         tick();
         if ($urandom_range(0, 999) == 0) begin
            rst = 1'b1;
            req = '0;
            model_reset();
            #1;
            check_eq("rnd_rst_blank", HEX2, 7'h7F);
            tick();
            rst = 1'b0;
            for (int i = 0; i < 3; i++) wt[i] = 0;
         end else begin
            for (int i = 0; i < 3; i++) begin
               if (req[i]) begin
                  wt[i]++;
                  if (grant[i]) begin
                     check_eq("rnd_wait_ok", wt[i] <= NREQ * (DWELL + 1) + 1, 1);
                     req[i] = 1'b0;
                  end else if ($urandom_range(0, 40) == 0) begin
                     req[i] = 1'b0;
                  end
               end else if ($urandom_range(0, 7) == 0) begin
                  data[16*i +: 16] = 16'($urandom);
                  req[i] = 1'b1;
                  wt[i] = 0;
               end
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
